// File: rtl/tetris_pkg.sv
// Shared types for the piece scheduler: piece code width, piece names, and scheduler states.
package tetris_pkg;

  localparam int PIECE_W = 2;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I = 2'd0,
    PIECE_O = 2'd1,
    PIECE_T = 2'd2,
    PIECE_L = 2'd3
  } piece_t;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } sched_state_t;

endpackage

// File: rtl/piece_scheduler_if.sv
// Handshake and preview bundle between the piece scheduler (slave) and the game FSM (master).
interface piece_scheduler_if #(
  parameter int PIECE_W     = tetris_pkg::PIECE_W,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic               piece_req;
  logic               piece_valid;
  logic [PIECE_W-1:0] piece_out;
  logic [PIECE_W-1:0] next_piece;
  logic [CNT_W-1:0]   queue_count;
  logic               filling;

  modport master (
    output piece_req,
    input  piece_valid, piece_out, next_piece, queue_count, filling
  );

  modport slave (
    input  piece_req,
    output piece_valid, piece_out, next_piece, queue_count, filling
  );
endinterface

// File: rtl/piece_scheduler_fifo.sv
// Circular piece buffer with head/next preview and synchronous clear (clear beats push/pop).
module piece_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clka,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [W-1:0]           head_o,
  output logic [W-1:0]           next_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);
  assign rd_nxt  = rd_ptr_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_nxt;
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = (count_q >= TWO) ? mem_q[rd_nxt] : '0;

endmodule

// File: rtl/piece_scheduler.sv
// Samples rng piece codes on a fixed cadence into a small queue and serves them to the game FSM.
// Optional PIECE_NOREPEAT_EN rejects a sample equal to the last pushed piece (max two in a row).
//
// state | meaning
// FILL  | queue not full, sampling whenever the gap counter expires
// READY | queue full, sampling only alongside a pop
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PIECE_W     = tetris_pkg::PIECE_W,
  parameter int SAMPLE_GAP  = 3
) (
  input  logic               clka,
  input  logic               restart,
  input  logic [PIECE_W-1:0] rand_in,
  piece_scheduler_if.slave   sched
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int GAP_W = (SAMPLE_GAP > 0) ? $clog2(SAMPLE_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(QUEUE_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP);

  sched_state_t       state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [PIECE_W-1:0] head, next;
  logic               pop, slot, accept, push;

  assign pop  = sched.piece_req && (count != '0);
  assign slot = (gap_q == '0) && ((count != FULL) || pop);
  assign push = slot && accept;

`ifdef PIECE_NOREPEAT_EN
  logic [PIECE_W-1:0] last_q, last_d;
  logic [1:0]         rej_q, rej_d;

  // After two rejections in a row the sample is taken regardless, so a stuck rng still fills.
  assign accept = (rand_in != last_q) || (rej_q == 2'd2);

  always_comb begin
    last_d = last_q;
    rej_d  = rej_q;
    if (slot) begin
      if (accept) begin
        last_d = rand_in;
        rej_d  = 2'd0;
      end else begin
        rej_d = rej_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      last_q <= '0;
      rej_q  <= '0;
    end else begin
      last_q <= last_d;
      rej_q  <= rej_d;
    end
  end
`else
  assign accept = 1'b1;
`endif

  piece_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (PIECE_W)
  ) u_fifo (
    .clka    (clka),
    .clear_i (restart),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rand_in),
    .count_o (count),
    .head_o  (head),
    .next_o  (next)
  );

  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + 1'b1;
    end else if (pop && !push) begin
      count_d = count - 1'b1;
    end
  end

  // A rejected sample reloads exactly like a push; a pop out of READY restarts the refill gap.
  always_comb begin
    gap_d = gap_q;
    if (slot || (pop && (state_q == READY))) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q <= FILL;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (count_d == FULL) state_d = READY;
      READY:   if (count_d != FULL) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    sched.piece_valid = (count != '0);
    sched.piece_out   = '0;
    if (count != '0) begin
      sched.piece_out = head;
    end
    sched.next_piece  = next;
    sched.queue_count = count;
    sched.filling     = (state_q == FILL);
  end

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: directed vector table, hand sequences, random vs queue model.
module tb_piece_scheduler;
  localparam int QD = 4;
  localparam int PW = 2;
  localparam int SG = 3;

  logic          clka = 1'b0;
  logic          restart = 1'b1;
  logic [PW-1:0] rand_in = '0;

  piece_scheduler_if #(.PIECE_W(PW), .QUEUE_DEPTH(QD)) sif ();

  piece_scheduler #(
    .QUEUE_DEPTH (QD),
    .PIECE_W     (PW),
    .SAMPLE_GAP  (SG)
  ) dut (
    .clka    (clka),
    .restart (restart),
    .rand_in (rand_in),
    .sched   (sif)
  );

  always #5 clka = ~clka;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: a queue of pieces plus "cycles until next sample slot".
  int mq[$];
  int mgap = 0;
`ifdef PIECE_NOREPEAT_EN
  int mlast = 0;
  int mrej  = 0;
`endif

  typedef struct {
    bit r; int d; bit req;
    int cnt; int val; int out; int nxt; int fill;
  } vec_t;
  vec_t tab[$];

  function automatic void add(bit r, int d, bit req, int cnt, int val, int out, int nxt, int fill);
    vec_t v;
    v = '{r, d, req, cnt, val, out, nxt, fill};
    tab.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input int d, input bit req);
    bit pop, slot, acc, was_full;
    if (r) begin
      mq.delete();
      mgap = 0;
`ifdef PIECE_NOREPEAT_EN
      mlast = 0;
      mrej  = 0;
`endif
      return;
    end
    was_full = (mq.size() == QD);
    pop  = req && (mq.size() > 0);
    slot = (mgap == 0) && ((mq.size() < QD) || pop);
    acc  = 1'b1;
`ifdef PIECE_NOREPEAT_EN
    acc = (d != mlast) || (mrej == 2);
`endif
    if (pop) void'(mq.pop_front());
    if (slot && acc) mq.push_back(d);
`ifdef PIECE_NOREPEAT_EN
    if (slot) begin
      if (acc) begin
        mlast = d;
        mrej  = 0;
      end else begin
        mrej++;
      end
    end
`endif
    if (slot || (pop && was_full)) mgap = SG;
    else if (mgap > 0) mgap--;
  endtask

  task automatic cycle(input bit r, input int d, input bit req);
    restart       = r;
    rand_in       = PW'(d);
    sif.piece_req = req;
    @(posedge clka);
    model_step(r, d, req);
    @(negedge clka);
  endtask

  task automatic chk_dut(input string tag, input int cnt, input int val, input int out,
                         input int nxt, input int fill);
    chk({tag, ".count"}, int'(sif.queue_count), cnt);
    chk({tag, ".valid"}, int'(sif.piece_valid), val);
    if (val != 0) chk({tag, ".out"}, int'(sif.piece_out), out);
    chk({tag, ".next"}, int'(sif.next_piece), nxt);
    chk({tag, ".filling"}, int'(sif.filling), fill);
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = mq.size();
    chk_dut(tag, sz, (sz != 0) ? 1 : 0, (sz != 0) ? mq[0] : 0,
            (sz >= 2) ? mq[1] : 0, (sz != QD) ? 1 : 0);
  endtask

  initial begin
    int reqp[6];
    sif.piece_req = 1'b0;
    @(negedge clka);

    // restart, fill 1,2,3,0 at edges 1/5/9/13, pop, refill, full push+pop, drain
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1, 0, 1);
    for (int k = 2; k <= 4; k++) add(0, 2, 0, 1, 1, 1, 0, 1);
    add(0, 2, 0, 2, 1, 1, 2, 1);
    for (int k = 6; k <= 8; k++) add(0, 3, 0, 2, 1, 1, 2, 1);
    add(0, 3, 0, 3, 1, 1, 2, 1);
    for (int k = 10; k <= 12; k++) add(0, 0, 0, 3, 1, 1, 2, 1);
    add(0, 0, 0, 4, 1, 1, 2, 0);
    add(0, 1, 1, 3, 1, 2, 3, 1);
    for (int k = 15; k <= 17; k++) add(0, 1, 0, 3, 1, 2, 3, 1);
    add(0, 1, 0, 4, 1, 2, 3, 0);
    for (int k = 19; k <= 21; k++) add(0, 2, 0, 4, 1, 2, 3, 0);
    add(0, 2, 1, 4, 1, 3, 0, 0);
    add(0, 2, 1, 3, 1, 0, 1, 1);
    add(0, 2, 1, 2, 1, 1, 2, 1);
    add(0, 2, 1, 1, 1, 2, 0, 1);
    add(0, 3, 0, 1, 1, 2, 0, 1);
    add(0, 3, 0, 2, 1, 2, 3, 1);

    for (int i = 0; i < tab.size(); i++) begin
      cycle(tab[i].r, tab[i].d, tab[i].req);
      chk_dut($sformatf("vec%0d", i), tab[i].cnt, tab[i].val, tab[i].out, tab[i].nxt, tab[i].fill);
    end

    // restart with a same-cycle request: pop suppressed, refill at edge 1
    cycle(1, 1, 1);
    chk_dut("rst_req", 0, 0, 0, 0, 1);
    cycle(0, 1, 0);
    chk_dut("rst_refill", 1, 1, 1, 0, 1);

    // requests against an empty queue are ignored, not remembered
    cycle(1, 0, 0);
    cycle(0, 3, 0);
    chk_dut("emp_push", 1, 1, 3, 0, 1);
    cycle(0, 0, 1);
    chk_dut("emp_pop", 0, 0, 0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk_dut("emp_idle", 0, 0, 0, 0, 1);
    cycle(0, 1, 1);
    chk_dut("emp_first", 1, 1, 1, 0, 1);
    cycle(0, 2, 0);
    chk_dut("emp_hold", 1, 1, 1, 0, 1);

`ifdef PIECE_NOREPEAT_EN
    // zero right after restart is rejected; a stuck 3 is accepted every third slot
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk_dut("nr_zero", 0, 0, 0, 0, 1);
    for (int k = 2; k <= 17; k++) begin
      cycle(0, 3, 0);
      if (k == 5)  chk_dut("nr_acc1", 1, 1, 3, 0, 1);
      if (k == 13) chk_dut("nr_rej2", 1, 1, 3, 0, 1);
      if (k == 17) chk_dut("nr_acc2", 2, 1, 3, 3, 1);
    end
`endif

    // randomized phases with varying request pressure and occasional stuck rng
    reqp = '{5, 30, 60, 90, 20, 50};
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit r, q;
      int d;
      ph = i / 500;
      r  = ($urandom_range(0, 199) == 0);
      d  = (ph == 4) ? 2 : int'($urandom_range(0, 3));
      q  = ($urandom_range(0, 99) < reqp[ph]);
      cycle(r, d, q);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
